// File: rtl/apb_req_sched_pkg.sv
// Shared types for the APB request scheduler: FSM state encoding and the
// width of the slave-select field carried in the request address.
package apb_sched_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/apb_req_sched_if.sv
// Requester-side handshakes plus the APB/mux control bus of the scheduler.
// valid/ready: a request moves when req_valid and req_ready are both high in
// the same cycle; a response moves when rsp_valid and rsp_ready are both high.
interface apb_req_sched_if #(
  parameter int NUM_REQ = 2
);
  import apb_sched_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic [31:0]              paddr;
  logic                     pwrite;
  logic [31:0]              pwdata;
  logic                     penable;
  logic                     ctrl_psel;
  logic [SEL_W-1:0]         ctrl_addr_mux;
  logic [31:0]              ctrl_prdata;
  logic                     ctrl_pready;
  logic                     ctrl_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
           ctrl_prdata, ctrl_pready, ctrl_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, pwdata, penable, ctrl_psel, ctrl_addr_mux
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
           ctrl_prdata, ctrl_pready, ctrl_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, pwdata, penable, ctrl_psel, ctrl_addr_mux
  );

endinterface

// File: rtl/apb_req_sched_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward
// from ptr, wrapping modulo NUM_REQ.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_sched.sv
// Round-robin scheduler that sequences one APB transfer at a time onto the
// shared slave mux and returns data/error to the granted requester.
module apb_req_sched
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_req_sched_if.master       bus,
  output state_t                state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   arb_grant;
  logic               arb_valid;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        paddr_q;
  logic               pwrite_q;
  logic [31:0]        pwdata_q;
  logic               psel_q;
  logic               penable_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (bus.req_valid),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // The accept pulse is combinational so the grant and the register capture
  // happen in the same IDLE cycle.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && arb_valid) bus.req_ready[arb_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_q    <= arb_grant;
            paddr_q  <= bus.req_addr[arb_grant];
            pwrite_q <= bus.req_write[arb_grant];
            pwdata_q <= bus.req_wdata[arb_grant];
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          cnt_q     <= '0;
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          // pready wins over an expiring timeout in the same cycle.
          if (bus.ctrl_pready) begin
            rdata_q            <= pwrite_q ? 32'h0 : bus.ctrl_prdata;
            err_q              <= bus.ctrl_pslverr;
            psel_q             <= 1'b0;
            penable_q          <= 1'b0;
            rsp_valid_q        <= '0;
            rsp_valid_q[gnt_q] <= 1'b1;
            state              <= RESP;
          end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
            rdata_q            <= 32'h0;
            err_q              <= 1'b1;
            psel_q             <= 1'b0;
            penable_q          <= 1'b0;
            rsp_valid_q        <= '0;
            rsp_valid_q[gnt_q] <= 1'b1;
            state              <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.paddr         = paddr_q;
  assign bus.pwrite        = pwrite_q;
  assign bus.pwdata        = pwdata_q;
  assign bus.ctrl_psel     = psel_q;
  assign bus.penable       = penable_q;
  assign bus.ctrl_addr_mux = paddr_q[SEL_LSB +: SEL_W];
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;

endmodule

// File: tb/tb_apb_req_sched.sv
// Directed bench for apb_req_sched: one task per scenario with inline checks
// against hand-computed values; a simple mux model answers the APB side.
module tb_apb_req_sched;
  import apb_sched_pkg::*;

  localparam int NUM_REQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  state_t      dbg_state;
  logic        slave_hang;
  logic [31:0] slave_rdata;
  int          vectors = 0;
  int          miscompares = 0;

  apb_req_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  apb_req_sched #(
    .NUM_REQ (NUM_REQ),
    .SEL_LSB (12),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Mux model: answers in the first ACCESS cycle unless hung; indices >= 8 error.
  assign bus.ctrl_pready  = bus.ctrl_psel & bus.penable & ~slave_hang;
  assign bus.ctrl_pslverr = bus.ctrl_psel & bus.penable & (bus.ctrl_addr_mux >= 4'd8);
  assign bus.ctrl_prdata  = bus.ctrl_pslverr ? 32'h0 : slave_rdata;

  // driver tasks
  task automatic drive_req(input int r, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd);
    bus.req_addr[r]  = addr;
    bus.req_write[r] = wr;
    bus.req_wdata[r] = wd;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = '0;
    slave_hang    = 1'b0;
    slave_rdata   = 32'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    vectors++;
    if ({bus.ctrl_psel, bus.penable, bus.pwrite, bus.rsp_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: psel/penable/pwrite/err=%b expected 0000",
               {bus.ctrl_psel, bus.penable, bus.pwrite, bus.rsp_err});
    end
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.ctrl_addr_mux} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b addr_mux=%h expected 0",
               bus.req_ready, bus.rsp_valid, bus.ctrl_addr_mux);
    end
    vectors++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h expected 0",
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [2];
    logic [31:0] exp_wd;
    logic [1:0]  exp_oh;
    int          g;
    wd[0] = 32'h1111_0000;
    wd[1] = 32'h2222_0000;
    slave_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    drive_req(0, 32'h0000_5000, 1'b1, wd[0]);
    drive_req(1, 32'h0000_6004, 1'b1, wd[1]);
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g      = k % 2;
      exp_oh = 2'b01 << g;
      exp_wd = wd[g];
      #1;
      vectors++;
      if (bus.req_ready !== exp_oh) begin
        miscompares++; $display("FAIL b2b_grant%0d: req_ready=%b expected %b", k, bus.req_ready, exp_oh);
      end
      @(negedge clk);
      wd[g] = wd[g] + 32'd1;
      bus.req_wdata[g] = wd[g];
      vectors++;
      if ({bus.ctrl_psel, bus.penable, bus.pwrite, bus.pwdata} !== {3'b101, exp_wd}) begin
        miscompares++;
        $display("FAIL b2b_setup%0d: psel/en/wr=%b pwdata=%h expected 101 %h", k,
                 {bus.ctrl_psel, bus.penable, bus.pwrite}, bus.pwdata, exp_wd);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {exp_oh, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL b2b_resp%0d: rsp_valid=%b err=%b rdata=%h expected %b 0 0", k,
                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, exp_oh);
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    slave_rdata = 32'hDEAD_BEEF;
    drive_req(0, 32'h0000_2004, 1'b0, 32'h0);
    #1;
    vectors++;
    if ({bus.req_ready, bus.ctrl_psel} !== 3'b010) begin
      miscompares++;
      $display("FAIL read_accept: req_ready=%b psel=%b expected 01 0", bus.req_ready, bus.ctrl_psel);
    end
    @(negedge clk);
    bus.req_valid = '0;
    vectors++;
    if ({bus.ctrl_psel, bus.penable, bus.ctrl_addr_mux, bus.paddr} !== {2'b10, 4'd2, 32'h0000_2004}) begin
      miscompares++;
      $display("FAIL read_setup: psel/en=%b addr_mux=%0d paddr=%h expected 10 2 00002004",
               {bus.ctrl_psel, bus.penable}, bus.ctrl_addr_mux, bus.paddr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ctrl_psel, bus.penable, bus.rsp_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL read_access: psel/en=%b rsp_valid=%b expected 11 00",
               {bus.ctrl_psel, bus.penable}, bus.rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ctrl_psel} !== {2'b01, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL read_resp: rsp_valid=%b err=%b rdata=%h psel=%b expected 01 0 deadbeef 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ctrl_psel);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = '0;
    vectors++;
    if (bus.rsp_valid !== 2'b00 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL read_done: rsp_valid=%b state=%0d expected 00 0", bus.rsp_valid, dbg_state);
    end
  endtask

  task automatic test_bad_slave();
    @(negedge clk);
    slave_rdata = 32'h1234_5678;
    drive_req(0, 32'h0000_9000, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = '0;
    vectors++;
    if (bus.ctrl_addr_mux !== 4'd9) begin
      miscompares++; $display("FAIL bad_idx: addr_mux=%0d expected 9", bus.ctrl_addr_mux);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL bad_resp: rsp_valid=%b err=%b rdata=%h expected 01 1 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    slave_rdata = 32'hCAFE_F00D;
    drive_req(0, 32'h0000_1008, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    drive_req(1, 32'h0000_3010, 1'b0, 32'h0);
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    for (int j = 0; j < 5; j++) begin
      #1;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, bus.ctrl_psel, bus.penable}
          !== {2'b01, 1'b0, 32'hCAFE_F00D, 2'b00, 2'b00}) begin
        miscompares++;
        $display("FAIL stall%0d: rsp_valid=%b err=%b rdata=%h req_ready=%b psel/en=%b", j,
                 bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready,
                 {bus.ctrl_psel, bus.penable});
      end
      @(negedge clk);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.req_ready} !== 4'b0010) begin
      miscompares++;
      $display("FAIL stall_release: rsp_valid=%b req_ready=%b expected 00 10",
               bus.rsp_valid, bus.req_ready);
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL stall_next: rsp_valid=%b rdata=%h expected 10 cafef00d",
               bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
    bus.rsp_ready = '0;
  endtask

  task automatic test_timeout();
    int  n_access;
    logic found;
    n_access = 0;
    found    = 1'b0;
    @(negedge clk);
    slave_hang = 1'b1;
    drive_req(1, 32'h0000_3000, 1'b0, 32'h0);
    #1;
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++; $display("FAIL to_accept: req_ready=%b expected 10", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) found = 1'b1;
      else if (bus.ctrl_psel && bus.penable) n_access++;
    end
    vectors++;
    if (!found || n_access != 4) begin
      miscompares++;
      $display("FAIL to_cycles: found=%b access_cycles=%0d expected 1 4", found, n_access);
    end
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ctrl_psel, bus.penable}
        !== {2'b10, 1'b1, 32'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL to_resp: rsp_valid=%b err=%b rdata=%h psel/en=%b expected 10 1 0 00",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, {bus.ctrl_psel, bus.penable});
    end
    slave_hang    = 1'b0;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid();
    // One completed transfer from requester 0 moves the pointer to 1.
    @(negedge clk);
    slave_rdata = 32'h0BAD_F00D;
    drive_req(0, 32'h0000_4000, 1'b0, 32'h0);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = '0;
    drive_req(0, 32'h0000_4004, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.ctrl_psel, bus.penable} !== 2'b11) begin
      miscompares++; $display("FAIL rst_pre: psel/en=%b expected 11", {bus.ctrl_psel, bus.penable});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ctrl_psel, bus.penable, bus.rsp_valid} !== 4'b0000 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL rst_async: psel/en=%b rsp_valid=%b state=%0d expected 00 00 0",
               {bus.ctrl_psel, bus.penable}, bus.rsp_valid, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, 32'h0000_4008, 1'b0, 32'h0);
    drive_req(1, 32'h0000_400C, 1'b0, 32'h0);
    bus.rsp_ready = 2'b11;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL rst_ptr: req_ready=%b expected 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++; $display("FAIL rst_req1: req_ready=%b expected 10", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 2'b10) begin
      miscompares++; $display("FAIL rst_req1_resp: rsp_valid=%b expected 10", bus.rsp_valid);
    end
    @(negedge clk);
    bus.rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_read();
    test_bad_slave();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_req_sched.md
Name: apb_req_sched

Overview:
- Sequences APB transfers onto the shared 8-slave APB mux.
- Arbitrates round-robin between NUM_REQ requesters.
- Drives the APB setup and access phases, and the slave-select index into the mux.
- Returns read data and error status to the granted requester, and bounds every access with a timeout.

Parameters:
NUM_REQ, 2, number of requesters; must be at least 2.
SEL_LSB, 12, LSB of the 4-bit slave index field inside req_addr.
TIMEOUT, 255, maximum ACCESS cycles before forced error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester transfer request
req_ready  out  NUM_REQ  one-cycle accept pulse for the granted requester
req_addr  in  NUM_REQ x 32  request address
req_write  in  NUM_REQ  1 = write, 0 = read
req_wdata  in  NUM_REQ x 32  write data
rsp_valid  out  NUM_REQ  response valid, asserted to the granted requester only
rsp_ready  in  NUM_REQ  response accept
rsp_rdata  out  32  read data, shared by all requesters
rsp_err  out  1  error flag, shared by all requesters
paddr  out  32  APB address
pwrite  out  1  APB write
pwdata  out  32  APB write data
penable  out  1  APB enable
ctrl_psel  out  1  select to the mux
ctrl_addr_mux  out  4  slave index to the mux, equal to paddr[SEL_LSB+3:SEL_LSB]
ctrl_prdata  in  32  read data from the mux
ctrl_pready  in  1  ready from the mux
ctrl_pslverr  in  1  slave error from the mux

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; every output 0; round-robin pointer 0; timeout counter 0. Reset asserted mid-transfer drops ctrl_psel and penable immediately, and the in-flight transfer is lost.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester found scanning upward from the pointer, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_ready[grant] and register addr, write and wdata. Next state is SETUP.
  - With no request, stay in IDLE.
- SETUP: ctrl_psel=1, penable=0; paddr, pwrite, pwdata and ctrl_addr_mux come from registers. Clear the counter. Next state is ACCESS.
- ACCESS: ctrl_psel=1, penable=1; the counter increments each cycle.
  - If ctrl_pready=1: latch rsp_rdata = ctrl_prdata on reads and 0 on writes; latch rsp_err = ctrl_pslverr. Next state is RESP.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1: rsp_rdata=0, rsp_err=1. Next state is RESP.
  - ctrl_pready takes priority over timeout when both occur in the same cycle.
- RESP: ctrl_psel=0, penable=0; rsp_valid[grant]=1, with rdata and err stable.
  - Hold until rsp_ready[grant]=1.
  - On that cycle, set pointer = (grant+1) mod NUM_REQ. Next state is IDLE.
- APB bus hold rules:
  - paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
  - Outside SETUP and ACCESS, they hold their last value.
- Minimum latency: 4 cycles from the accept cycle to the first rsp_valid cycle (accept, SETUP, ACCESS, RESP). Throughput is at most one transfer per 4 cycles plus response backpressure.
- Out-of-range slave index (>= 8): the mux returns pready=1 and pslverr=1, so the transfer completes after one ACCESS cycle with rsp_err=1 and rdata=0. No special casing is needed in this block.
- Requesters hold req_valid and their request fields stable until req_ready. Changes to req_valid outside IDLE are ignored. A requester that is not granted sees req_ready=0.
- rsp_ready for non-granted requesters is ignored.
- Only one transfer is outstanding at any time. rsp_valid is one-hot or zero.

Decomposition:
- Shared package apb_sched_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS, RESP, 2 bits);
  - the SEL field width constant (4).
- One natural sub-module: apb_rr_arbiter. It is combinational, with inputs req vector and pointer and outputs grant index and grant-valid.

Test Plan:
- Single read, requester 0, addr 0x0000_2004, slave returns prdata 0xDEADBEEF with pready on the first ACCESS cycle -> ctrl_addr_mux=2; psel rises in the cycle after accept; rsp_valid[0] on cycle 4 with rdata 0xDEADBEEF, err 0.
- Both requesters valid every cycle, pointer 0, responses accepted immediately -> grants alternate 0,1,0,1. Each write carries its own wdata on pwdata, and rsp_rdata=0.
- Address with slave index 9 (addr 0x0000_9000) -> one ACCESS cycle, rsp_err=1, rsp_rdata=0.
- Slave holds pready=0, TIMEOUT=4 -> exactly 4 ACCESS cycles, then RESP with err=1; psel drops on the RESP cycle.
- rsp_ready held low for 5 cycles -> rsp_valid, rdata and err stay stable, no new accept occurs, and the bus stays idle.
- rst_n pulled low during ACCESS -> psel, penable and rsp_valid go to 0 asynchronously; after release, a fresh request from requester 1 is granted with pointer 0 behaviour.
